// File: rtl/exec_pkg.sv
// Shared encodings, FSM states, AXI constants and helpers for the exec_lsu load/store unit.
package exec_pkg;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_RSV = 2'd3;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] CACHE_DEF  = 4'b0011;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_D = 3'd2,
        S_WR   = 3'd3,
        S_WR_B = 3'd4,
        S_RESP = 3'd5
    } lsu_state_e;

    function automatic int lane_off_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_RSV) || (size == SZ_W && lo != 2'b00) || (size == SZ_H && lo[0]);
    endfunction

endpackage

// File: rtl/exec_lsu_lane.sv
// Combinational byte-lane steering: store data/strobe placement and load extract with extension.
module exec_lsu_lane
    import exec_pkg::*;
#(
    parameter int DATA_W = 512,
    localparam int OFF    = lane_off_bits(DATA_W),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic [OFF-1:0]    off_i,
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    input  logic [31:0]       wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [31:0]       rdata_o
);

    logic [31:0] wd_rot;
    logic [3:0]  size_mask;
    logic [31:0] raw;

    always_comb begin
        // Rotate so datum byte 0 lands on the lane offset within every 32-bit group.
        case (off_i[1:0])
            2'd1:    wd_rot = {wdata_i[23:0], wdata_i[31:24]};
            2'd2:    wd_rot = {wdata_i[15:0], wdata_i[31:16]};
            2'd3:    wd_rot = {wdata_i[7:0],  wdata_i[31:8]};
            default: wd_rot = wdata_i;
        endcase
        wdata_o = {(DATA_W / 32){wd_rot}};

        case (size_i)
            SZ_B:    size_mask = 4'h1;
            SZ_H:    size_mask = 4'h3;
            default: size_mask = 4'hF;
        endcase
        wstrb_o = STRB_W'(size_mask) << off_i;

        raw = 32'(rdata_i >> {off_i, 3'b000});
        case (size_i)
            SZ_B:    rdata_o = {{24{sign_i & raw[7]}},  raw[7:0]};
            SZ_H:    rdata_o = {{16{sign_i & raw[15]}}, raw[15:0]};
            default: rdata_o = raw;
        endcase
    end

endmodule

// File: rtl/exec_lsu.sv
// Single-beat AXI4 load/store unit. Optional macro EXEC_LSU_MISALIGN_CHECK_EN: misaligned
// requests complete with an error instead of being force-aligned.
// state  | meaning
// IDLE   | ready for a request
// RD_A   | AR issued, R accepted alongside
// RD_D   | waiting for R beat
// WR     | AW and W outstanding
// WR_B   | waiting for B
// RESP   | one-cycle completion pulse
module exec_lsu
    import exec_pkg::*;
#(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 512,
    parameter int ID_W   = 4,
    parameter int AXI_ID = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic [4:0]            resp_rd,
    output logic                  resp_err,
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [2:0]            arsize,
    output logic [ID_W-1:0]       arid,
    output logic [7:0]            arlen,
    output logic [1:0]            arburst,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic [3:0]            arqos,
    output logic                  arlock,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic                  rlast,
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [2:0]            awsize,
    output logic [ID_W-1:0]       awid,
    output logic [7:0]            awlen,
    output logic [1:0]            awburst,
    output logic [3:0]            awcache,
    output logic [2:0]            awprot,
    output logic [3:0]            awqos,
    output logic                  awlock,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int OFF    = lane_off_bits(DATA_W);
    localparam int STRB_W = DATA_W / 8;

    lsu_state_e          state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic                aw_done_q, w_done_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [31:0]         resp_data_q;
    logic [4:0]          resp_rd_q;
    logic                resp_err_q;

    logic [ADDR_W-1:0]   addr_eff;
    logic [1:0]          size_eff;
    logic                misalign;
    logic [OFF-1:0]      lane_off;
    logic [1:0]          lane_size;
    logic [DATA_W-1:0]   lane_wdata;
    logic [STRB_W-1:0]   lane_wstrb;
    logic [31:0]         lane_rdata;
    logic                aw_now, w_now;
    logic                unused_ok;

    always_comb begin
        size_eff = req_size;
        addr_eff = req_addr;
        misalign = 1'b0;
`ifdef EXEC_LSU_MISALIGN_CHECK_EN
        misalign = is_misaligned(req_size, req_addr[1:0]);
`else
        if (req_size == SZ_RSV) size_eff = SZ_W;
        if (size_eff == SZ_H) addr_eff[0] = 1'b0;
        else if (size_eff == SZ_W) addr_eff[1:0] = 2'b00;
`endif
    end

    // Insert path works on the incoming request, extract path on the latched one.
    assign lane_off  = (state_q == S_IDLE) ? addr_eff[OFF-1:0] : addr_q[OFF-1:0];
    assign lane_size = (state_q == S_IDLE) ? size_eff : size_q;

    exec_lsu_lane #(.DATA_W(DATA_W)) u_lane (
        .off_i   (lane_off),
        .size_i  (lane_size),
        .sign_i  (signed_q),
        .wdata_i (req_wdata),
        .rdata_i (rdata),
        .wdata_o (lane_wdata),
        .wstrb_o (lane_wstrb),
        .rdata_o (lane_rdata)
    );

    assign aw_now = aw_done_q | (awvalid_q & awready);
    assign w_now  = w_done_q  | (wvalid_q & wready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            resp_data_q <= '0;
            resp_rd_q   <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    addr_q      <= addr_eff;
                    size_q      <= size_eff;
                    signed_q    <= req_signed;
                    resp_rd_q   <= req_rd;
                    resp_data_q <= '0;
                    resp_err_q  <= 1'b0;
                    if (misalign) begin
                        resp_err_q <= 1'b1;
                        state_q    <= S_RESP;
                    end else if (req_store) begin
                        wdata_q   <= lane_wdata;
                        wstrb_q   <= lane_wstrb;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        bready_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= S_WR;
                    end else begin
                        arvalid_q <= 1'b1;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_A;
                    end
                end
                S_RD_A: if (arready) begin
                    arvalid_q <= 1'b0;
                    if (rvalid) begin
                        resp_data_q <= lane_rdata;
                        resp_err_q  <= rresp[1];
                        rready_q    <= 1'b0;
                        state_q     <= S_RESP;
                    end else begin
                        state_q <= S_RD_D;
                    end
                end
                S_RD_D: if (rvalid) begin
                    resp_data_q <= lane_rdata;
                    resp_err_q  <= rresp[1];
                    rready_q    <= 1'b0;
                    state_q     <= S_RESP;
                end
                S_WR: begin
                    if (awready) awvalid_q <= 1'b0;
                    if (wready)  wvalid_q  <= 1'b0;
                    aw_done_q <= aw_now;
                    w_done_q  <= w_now;
                    if (aw_now && w_now) state_q <= S_WR_B;
                end
                S_WR_B: if (bvalid) begin
                    resp_err_q <= bresp[1];
                    bready_q   <= 1'b0;
                    state_q    <= S_RESP;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = resp_err_q;

    assign araddr  = addr_q;
    assign arvalid = arvalid_q;
    assign arsize  = {1'b0, size_q};
    assign arid    = ID_W'(AXI_ID);
    assign arlen   = 8'd0;
    assign arburst = BURST_INCR;
    assign arcache = CACHE_DEF;
    assign arprot  = 3'd0;
    assign arqos   = 4'd0;
    assign arlock  = 1'b0;
    assign rready  = rready_q;

    assign awaddr  = addr_q;
    assign awvalid = awvalid_q;
    assign awsize  = {1'b0, size_q};
    assign awid    = ID_W'(AXI_ID);
    assign awlen   = 8'd0;
    assign awburst = BURST_INCR;
    assign awcache = CACHE_DEF;
    assign awprot  = 3'd0;
    assign awqos   = 4'd0;
    assign awlock  = 1'b0;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = wvalid_q;
    assign wlast   = wvalid_q;
    assign bready  = bready_q;

    // Single-beat bursts make rlast redundant; only the error bit of each resp matters.
    assign unused_ok = ^{rlast, rresp[0], bresp[0]};

endmodule
